// File: rtl/spi_flash_slave_wb.sv
// rtl/spi_flash_slave_wb.sv - SPI mode-0 serial-flash slave served from a byte-wide Wishbone memory
module spi_flash_slave_wb #(
    parameter int ADDR_BYTES   = 3,
    parameter int DUMMY_CYCLES = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    sck_i,
    input  logic                    ss_i,
    input  logic                    mosi_i,
    output logic                    miso_o,
    output logic                    miso_oe_o,
    output logic [8*ADDR_BYTES-1:0] wb_adr_o,
    output logic [7:0]              wb_dat_o,
    output logic                    wb_we_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    input  logic [7:0]              wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    output logic                    wel_o,
    output logic                    underrun_o,
    output logic                    overrun_o
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int DUMMY_LAST_I = (DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0;
    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_LAST_I);
    localparam logic [1:0] ADDR_LAST  = 2'(ADDR_BYTES - 1);

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FAST  = 8'h0B;
    localparam logic [7:0] OP_PROG  = 8'h02;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, STATUS, IGNORE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic                   sck_prev;
    logic                   sck_s, ss_s, mosi_s;
    logic                   rise, fall;

    logic [2:0]    bit_cnt;
    logic [6:0]    rx_shift;
    logic [7:0]    rx_byte;
    logic [AW-2:0] addr_sh;
    logic [AW-1:0] full_addr;
    logic [1:0]    addr_cnt;
    logic [3:0]    dummy_cnt;
    logic [7:0]    cmd;
    logic [6:0]    tx_shift;
    logic [7:0]    tx_byte;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] fetch_addr;
    logic [7:0]    buf_data;
    logic          buf_valid;
    logic          discard;
    logic          wrote_any;

    logic          byte_done, addr_done, is_rd_cmd;
    logic          bus_done, bus_free, rd_ret, have;
    logic [7:0]    rd_value;
    logic          load, shift, fetch_go, write_go;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign rise   = sck_s & ~sck_prev;
    assign fall   = ~sck_s & sck_prev;

    assign rx_byte   = {rx_shift, mosi_s};
    assign full_addr = {addr_sh, mosi_s};
    assign byte_done = rise && (bit_cnt == 3'd7);
    assign addr_done = (state == ADDR) && byte_done && (addr_cnt == ADDR_LAST);
    assign is_rd_cmd = (cmd == OP_READ) || (cmd == OP_FAST);

    // A cycle ending this edge frees the bus for a new one on the same edge
    assign bus_done = wb_cyc_o && (wb_ack_i || wb_err_i);
    assign bus_free = !wb_cyc_o || bus_done;
    assign rd_ret   = bus_done && !wb_we_o && !discard;
    assign rd_value = wb_err_i ? 8'hFF : wb_dat_i;
    assign have     = buf_valid || rd_ret;

    assign load  = !ss_s && fall && (bit_cnt == 3'd0) &&
                   ((state == RD_DATA) || (state == STATUS));
    assign shift = !ss_s && fall && (bit_cnt != 3'd0) &&
                   ((state == RD_DATA) || (state == STATUS));
    assign write_go = !ss_s && (state == WR_DATA) && byte_done && bus_free;

    // Byte handed to the TX shifter at a byte boundary
    always_comb begin
        tx_byte = 8'hFF;
        if (state == STATUS)
            tx_byte = {6'b0, wel_o, 1'b0};
        else if (buf_valid)
            tx_byte = buf_data;
        else if (rd_ret)
            tx_byte = rd_value;
    end

    // Read fetch: first at address completion, then refill whenever the buffer drains
    always_comb begin
        fetch_go   = 1'b0;
        fetch_addr = rd_addr;
        if (!ss_s) begin
            if (addr_done && is_rd_cmd) begin
                fetch_go   = bus_free;
                fetch_addr = full_addr;
            end else if (((state == RD_DATA) || (state == DUMMY)) && bus_free &&
                         (load || (!buf_valid && !rd_ret))) begin
                fetch_go = 1'b1;
            end
        end
    end

    // Pin synchronisers and previous synchronised SCK for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sck_prev  <= sck_s;
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Command decode and phase sequencing; deselect always returns to IDLE
    always_comb begin
        state_next = state;
        if (ss_s) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = CMD;
                CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            OP_READ, OP_FAST: state_next = ADDR;
                            OP_PROG:          state_next = wel_o ? ADDR : IGNORE;
                            OP_RDSR:          state_next = STATUS;
                            default:          state_next = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (addr_done) begin
                        if (cmd == OP_FAST)
                            state_next = (DUMMY_CYCLES > 0) ? DUMMY : RD_DATA;
                        else if (cmd == OP_READ)
                            state_next = RD_DATA;
                        else if (cmd == OP_PROG)
                            state_next = WR_DATA;
                        else
                            state_next = IGNORE;
                    end
                end
                DUMMY: begin
                    if (rise && (dummy_cnt == DUMMY_LAST))
                        state_next = RD_DATA;
                end
                default: state_next = state;
            endcase
        end
    end

    // Serial datapath, prefetch buffer, write-enable latch and Wishbone master
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            addr_sh    <= '0;
            addr_cnt   <= '0;
            dummy_cnt  <= '0;
            cmd        <= '0;
            tx_shift   <= '0;
            miso_o     <= 1'b0;
            miso_oe_o  <= 1'b0;
            rd_addr    <= '0;
            wr_addr    <= '0;
            buf_data   <= '0;
            buf_valid  <= 1'b0;
            discard    <= 1'b0;
            wrote_any  <= 1'b0;
            wel_o      <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            underrun_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            underrun_o <= 1'b0;
            overrun_o  <= 1'b0;
            miso_oe_o  <= (state_next == RD_DATA) || (state_next == STATUS);

            if (bus_done) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
                discard  <= 1'b0;
            end

            if (ss_s) begin
                bit_cnt   <= '0;
                rx_shift  <= '0;
                tx_shift  <= '0;
                miso_o    <= 1'b0;
                addr_cnt  <= '0;
                dummy_cnt <= '0;
                buf_valid <= 1'b0;
                cmd       <= '0;
                wrote_any <= 1'b0;
                if (wb_cyc_o && !bus_done)
                    discard <= 1'b1;
                if ((cmd == OP_PROG) && wrote_any)
                    wel_o <= 1'b0;
            end else begin
                if (rise) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= (state == DUMMY) ? 3'd0 : bit_cnt + 3'd1;
                    if (state == ADDR)
                        addr_sh <= full_addr[AW-2:0];
                    if (state == DUMMY)
                        dummy_cnt <= dummy_cnt + 4'd1;
                end

                if ((state == CMD) && byte_done) begin
                    cmd <= rx_byte;
                    if (rx_byte == OP_WREN)
                        wel_o <= 1'b1;
                    else if (rx_byte == OP_WRDI)
                        wel_o <= 1'b0;
                end

                if ((state == ADDR) && byte_done)
                    addr_cnt <= addr_cnt + 2'd1;

                if (addr_done)
                    wr_addr <= full_addr;

                if (rd_ret) begin
                    buf_data  <= rd_value;
                    buf_valid <= 1'b1;
                end

                if (load) begin
                    miso_o   <= tx_byte[7];
                    tx_shift <= tx_byte[6:0];
                    if (state == RD_DATA) begin
                        buf_valid <= 1'b0;
                        if (!have) begin
                            underrun_o <= 1'b1;
                            // The late data belongs to the byte just replaced by 0xFF
                            if (wb_cyc_o && !bus_done)
                                discard <= 1'b1;
                        end
                    end
                end else if (shift) begin
                    miso_o   <= tx_shift[6];
                    tx_shift <= {tx_shift[5:0], 1'b0};
                end

                if (fetch_go) begin
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    wb_we_o  <= 1'b0;
                    wb_adr_o <= fetch_addr;
                    rd_addr  <= fetch_addr + AW'(1);
                end else if (addr_done && is_rd_cmd) begin
                    rd_addr <= full_addr;
                end

                if (write_go) begin
                    wb_cyc_o      <= 1'b1;
                    wb_stb_o      <= 1'b1;
                    wb_we_o       <= 1'b1;
                    wb_adr_o      <= wr_addr;
                    wb_dat_o      <= rx_byte;
                    wr_addr[7:0]  <= wr_addr[7:0] + 8'd1;
                    wrote_any     <= 1'b1;
                end else if ((state == WR_DATA) && byte_done) begin
                    overrun_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_slave_wb.sv
// tb/tb_spi_flash_slave_wb.sv - directed self-checking bench for spi_flash_slave_wb
module tb_spi_flash_slave_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, miso_oe;
    logic [23:0] wb_adr;
    logic [7:0]  wb_wdat;
    logic [7:0]  wb_rdat = 8'h00;
    logic        wb_we, wb_cyc, wb_stb;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;
    logic        wel, underrun, overrun;

    int n_assert = 0;
    int n_fail   = 0;
    int ack_delay = 1;
    int ur_cnt = 0;
    int or_cnt = 0;
    int oe_cnt = 0;

    logic [23:0] log_adr[$];
    logic        log_we[$];
    logic [7:0]  log_dat[$];
    logic [7:0]  written[int];

    spi_flash_slave_wb dut (
        .clk_i(clk), .rst_i(rst), .sck_i(sck), .ss_i(ss), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_wdat), .wb_we_o(wb_we),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_dat_i(wb_rdat),
        .wb_ack_i(wb_ack), .wb_err_i(wb_err),
        .wel_o(wel), .underrun_o(underrun), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memval(input logic [23:0] a);
        if (written.exists(int'(a)))
            return written[int'(a)];
        return 8'h10 + a[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            wait_clk(4);
            rx[i] = miso;
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
        end
    endtask

    task automatic spi_start;
        ss = 1'b0;
        wait_clk(4);
    endtask

    task automatic spi_stop;
        wait_clk(4);
        ss = 1'b1;
        mosi = 1'b0;
        wait_clk(6);
        for (int k = 0; k < 200 && wb_cyc; k++)
            wait_clk(1);
    endtask

    task automatic clear_log;
        log_adr.delete();
        log_we.delete();
        log_dat.delete();
    endtask

    // Wishbone memory: acks after ack_delay cycles of a held strobe
    initial begin : wb_model
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (wb_ack) begin
                wb_ack = 1'b0;
            end else if (wb_cyc && wb_stb) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    cnt = 0;
                    log_adr.push_back(wb_adr);
                    log_we.push_back(wb_we);
                    log_dat.push_back(wb_wdat);
                    if (wb_we) begin
                        written[int'(wb_adr)] = wb_wdat;
                        wb_rdat = 8'h00;
                    end else begin
                        wb_rdat = memval(wb_adr);
                    end
                    wb_ack = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (underrun) ur_cnt++;
        if (overrun)  or_cnt++;
        if (miso_oe)  oe_cnt++;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] r;
        int oe0, ur0, or0, k;

        rst = 1'b1;
        wait_clk(3);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_wel", wel, 0);
        check("rst_cyc_stb", {wb_cyc, wb_stb, wb_we}, 0);
        check("rst_adr_dat", {wb_adr, wb_wdat}, 0);
        check("rst_pulses", {underrun, overrun}, 0);
        rst = 1'b0;
        wait_clk(4);

        // READ at 0x0000FE, four bytes crossing a 256-byte boundary
        clear_log();
        or0 = or_cnt;
        ur0 = ur_cnt;
        spi_start();
        spi_xfer(8'h03, r);
        spi_xfer(8'h00, r);
        spi_xfer(8'h00, r);
        spi_xfer(8'hFE, r);
        wait_clk(1);
        check("read_oe", miso_oe, 1);
        for (int b = 0; b < 4; b++) begin
            spi_xfer(8'h00, r);
            check($sformatf("read_byte%0d", b), r, 8'h0E + b);
        end
        spi_stop();
        check("read_log_len", log_adr.size() >= 5, 1);
        for (int b = 0; b < 5; b++)
            check($sformatf("read_adr%0d", b), {log_we[b], log_adr[b]}, 24'h0000FE + b);
        check("read_no_underrun", ur_cnt - ur0, 0);
        check("read_oe_off", miso_oe, 0);

        // FAST_READ at the top of the address space wraps to zero
        clear_log();
        spi_start();
        spi_xfer(8'h0B, r);
        spi_xfer(8'hFF, r);
        spi_xfer(8'hFF, r);
        spi_xfer(8'hFF, r);
        spi_xfer(8'h00, r);
        spi_xfer(8'h00, r);
        check("fast_byte0", r, 8'h0F);
        spi_xfer(8'h00, r);
        check("fast_byte1", r, 8'h10);
        spi_stop();
        check("fast_adr0", log_adr[0], 24'hFFFFFF);
        check("fast_adr1", log_adr[1], 24'h000000);

        // WREN, status read, PROGRAM with page wrap, WEL auto-clear
        spi_start();
        spi_xfer(8'h06, r);
        spi_stop();
        check("wren_wel", wel, 1);
        spi_start();
        spi_xfer(8'h05, r);
        spi_xfer(8'h00, r);
        spi_stop();
        check("rdsr_wel_set", r, 8'h02);

        clear_log();
        spi_start();
        spi_xfer(8'h02, r);
        spi_xfer(8'h00, r);
        spi_xfer(8'h00, r);
        spi_xfer(8'hFF, r);
        spi_xfer(8'hA5, r);
        spi_xfer(8'h5A, r);
        spi_stop();
        check("prog_log_len", log_adr.size(), 2);
        check("prog_wr0", {log_we[0], log_adr[0], log_dat[0]}, {1'b1, 24'h0000FF, 8'hA5});
        check("prog_wr1", {log_we[1], log_adr[1], log_dat[1]}, {1'b1, 24'h000000, 8'h5A});
        check("prog_wel_clr", wel, 0);
        check("prog_no_overrun", or_cnt - or0, 0);
        spi_start();
        spi_xfer(8'h05, r);
        spi_xfer(8'h00, r);
        spi_stop();
        check("rdsr_wel_clr", r, 8'h00);

        // PROGRAM without WREN is ignored
        clear_log();
        oe0 = oe_cnt;
        spi_start();
        spi_xfer(8'h02, r);
        spi_xfer(8'h00, r);
        spi_xfer(8'h00, r);
        spi_xfer(8'h10, r);
        spi_xfer(8'h33, r);
        spi_stop();
        check("nowren_no_write", log_adr.size(), 0);
        check("nowren_no_oe", oe_cnt - oe0, 0);

        // Slow memory: underrun, then deselect while a read is pending
        ack_delay = 40;
        ur0 = ur_cnt;
        spi_start();
        spi_xfer(8'h03, r);
        spi_xfer(8'h00, r);
        spi_xfer(8'h00, r);
        spi_xfer(8'h20, r);
        spi_xfer(8'h00, r);
        check("underrun_byte", r, 8'hFF);
        check("underrun_pulse", ur_cnt != ur0, 1);
        wait_clk(2);
        ss = 1'b1;
        wait_clk(6);
        check("dsel_cyc_held", {wb_cyc, wb_stb}, 2'b11);
        check("dsel_oe_off", miso_oe, 0);
        for (k = 0; k < 100 && wb_cyc; k++)
            wait_clk(1);
        check("dsel_cyc_release", wb_cyc, 0);
        wait_clk(4);
        check("dsel_idle_bus", wb_cyc, 0);
        ack_delay = 1;

        // Asynchronous reset in the middle of a status read
        spi_start();
        spi_xfer(8'h06, r);
        spi_stop();
        check("wren2_wel", wel, 1);
        spi_start();
        spi_xfer(8'h05, r);
        mosi = 1'b0;
        wait_clk(4);
        sck = 1'b1;
        wait_clk(2);
        check("pre_rst_oe", miso_oe, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_wel", wel, 0);
        check("async_rst_oe", {miso_oe, miso}, 0);
        check("async_rst_bus", {wb_cyc, wb_stb, wb_we, wb_adr}, 0);
        ss = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(4);
        oe0 = oe_cnt;
        spi_start();
        spi_xfer(8'h05, r);
        spi_xfer(8'h00, r);
        spi_stop();
        check("post_rst_rdsr", r, 8'h00);
        check("post_rst_oe_seen", oe_cnt != oe0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_slave_wb.md
# spi_flash_slave_wb

Parametrised SPI-mode-0 serial-flash slave that decodes a standard flash command subset and serves it from a byte-wide Wishbone memory. It sits between an external SPI master (boot ROM or SPI controller under test) and a `ram_wb_b3`-style memory. It generalises the previous read-only model in three ways:
- configurable address length;
- fast-read and write/status commands;
- SCK oversampling in the single `clk_i` domain, with read prefetch.

## Interface
Parameters:
- `ADDR_BYTES`, 3 — address bytes per command; legal values 3 or 4; `AW = 8*ADDR_BYTES`.
- `DUMMY_CYCLES`, 8 — SCK cycles between address and data for FAST_READ (0x0B); legal range 0..15.
- `SYNC_STAGES`, 2 — synchroniser depth on `sck_i`, `ss_i` and `mosi_i`; minimum 2.

Ports:
- Reset and clocking: one clock, `clk_i`; reset `rst_i` is asynchronous and active-high.
- `clk_i` in 1 — system clock; must run at ≥ 8× the SCK frequency.
- `rst_i` in 1 — asynchronous active-high reset.
- `sck_i` in 1 — SPI clock, mode 0.
- `ss_i` in 1 — slave select, active low.
- `mosi_i` in 1 — master-out data.
- `miso_o` out 1 — slave-out data, MSB first.
- `miso_oe_o` out 1 — high while the slave drives `miso_o` (data and status phases).
- `wb_adr_o` out AW — byte address.
- `wb_dat_o` out 8 — write data.
- `wb_we_o` out 1 — write enable.
- `wb_cyc_o`, `wb_stb_o` out 1 each — bus cycle and strobe.
- `wb_dat_i` in 8 — read data.
- `wb_ack_i`, `wb_err_i` in 1 each — cycle termination.
- `wel_o` out 1 — write-enable latch.
- `underrun_o` out 1 — one-cycle pulse when a read byte was not ready in time.
- `overrun_o` out 1 — one-cycle pulse when a program byte was dropped.

## Operation
Input capture:
- All three pins pass through `SYNC_STAGES` flops.
- Edge detect on the synchronised SCK produces `rise`/`fall` strobes.
- MOSI is shifted in on `rise`; MISO changes on `fall`.
- A bit counter (0..7) frames bytes.

State machine:
- IDLE → CMD on synchronised `ss` low.
- CMD: after 8 bits, decode the command byte:
  - 0x03 READ → ADDR.
  - 0x0B FAST_READ → ADDR.
  - 0x02 PROGRAM → ADDR if `wel_o`=1, else IGNORE.
  - 0x06 WREN → set WEL, then IGNORE.
  - 0x04 WRDI → clear WEL, then IGNORE.
  - 0x05 RDSR → STATUS.
  - Any other value → IGNORE.
- ADDR: shift in `ADDR_BYTES` bytes MSB first, then go to:
  - DUMMY for 0x0B when `DUMMY_CYCLES` > 0;
  - RD_DATA for 0x03, or for 0x0B when `DUMMY_CYCLES` = 0;
  - WR_DATA for 0x02.
- DUMMY: count `DUMMY_CYCLES` rises, ignoring MOSI, then go to RD_DATA.
- RD_DATA:
  - On completion of the last address bit, issue a Wishbone read at that address.
  - Each time a byte is loaded into the TX shifter, immediately prefetch address+1 into a one-byte buffer.
  - If the buffer is not valid at load time, load 0xFF and pulse `underrun_o`.
  - Address wraps modulo 2^AW.
- WR_DATA:
  - Each completed 8-bit byte issues a Wishbone write (`we`=1) at the current address.
  - Then the address low byte increments with 256-byte page wrap; the upper bits stay fixed.
  - If a byte completes while the previous write is still pending, drop the byte and pulse `overrun_o`.
- STATUS: transmit `{6'b0, wel, 1'b0}` repeatedly until deselect.
- IGNORE: consume bits and keep `miso_oe_o`=0.

Deselect:
- Synchronised `ss` high in any state → IDLE.
- Bit counter and shifters clear.
- `miso_oe_o` goes to 0 the next cycle.
- An in-flight Wishbone cycle holds `cyc`/`stb` until ack/err; its result is discarded.
- WEL clears at deselect if the transaction was PROGRAM with at least one byte written.

Wishbone:
- Single classic cycles only; `cyc_o` = `stb_o`.
- Outputs are held stable until `ack_i` or `err_i`, then deasserted the same edge.
- `err_i` on a read returns 0xFF; `err_i` on a write is treated as completion.
- At most one outstanding cycle.

## Timing
Reset values:
- All outputs are 0, including `miso_o`, `miso_oe_o`, `wel_o` and `wb_*`.
- State is IDLE.

Latencies and bus rules:
- Pin-to-strobe latency is `SYNC_STAGES`+1 clocks.
- `miso_o` updates on the clock edge that follows the `fall` strobe.
- The first read-data bit is driven on the `fall` that ends the last address bit (READ) or the last dummy bit (FAST_READ).
- Wishbone read issue: `wb_stb_o` asserts the cycle after the last-address-bit `rise` strobe.
- The first byte must be acked before the following `fall` strobe, else underrun.
- SCK ≤ `clk_i`/8 and ack latency ≤ 2 clocks together guarantee no underrun or overrun.

Simultaneous events:
- Deselect coinciding with a byte completion: the byte is discarded; no Wishbone write is issued.
- `ack_i` arriving on the same clock as a new byte load: the buffer is valid for that load.

## Test plan
- Reset with `rst_i` pulsed mid-transaction → all outputs 0 immediately (asynchronous); next `ss` low restarts at CMD.
- Memory preloaded with byte 0x10+k at address k; `ADDR_BYTES`=3, READ 0x03 at 0x0000FE, 4 bytes clocked → MISO returns 0x10E, 0x10F, 0x110, 0x111 truncated to 8 bits (0x0E, 0x0F, 0x10, 0x11); `wb_adr_o` sequence 0xFE..0x102.
- FAST_READ 0x0B at 0xFFFFFF with `DUMMY_CYCLES`=8, 2 bytes → data from 0xFFFFFF, then from 0x000000 (wrap).
- WREN, deselect; RDSR → 0x02. PROGRAM 0x02 at 0x0000FF writing 0xA5, 0x5A → writes 0xA5 to 0xFF and 0x5A to 0x00 (page wrap). After deselect, RDSR → 0x00.
- PROGRAM without a prior WREN → no Wishbone write; `miso_oe_o` stays 0.
- `wb_ack_i` delayed 40 clocks with SCK = `clk_i`/8 → `underrun_o` pulses and MISO byte reads 0xFF. Deselect during the pending cycle → `cyc_o` held until ack, then state is IDLE.
